k_fifo2_ctrl: RTL and testbench
===============================

# k_fifo2_ctrl

Pointer and flow-control sequencer for a 2-entry FIFO built on the team's 2-entry dual-port RAM. The RAM writes on the clk edge when wen is high and reads asynchronously. This block owns the write/read pointers, occupancy state machine, valid/ready handshakes on both sides, synchronous flush and a saturating stall counter. It carries no data: the RAM's d input comes from the producer and its q output goes to the consumer.

## Interface
- STALL_W, 8, width of stall_cnt

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- push_valid  input  1  producer has a word on RAM d
- push_ready  output  1  FIFO can accept a word this cycle
- pop_ready  input  1  consumer takes the word this cycle
- pop_valid  output  1  RAM q (at ram_raddr) holds a valid word
- flush  input  1  synchronous empty of the FIFO
- stall_clr  input  1  synchronous clear of stall_cnt
- ram_wen  output  1  RAM write enable
- ram_waddr  output  1  RAM write address
- ram_raddr  output  1  RAM read address
- count  output  2  occupancy, 0..2
- full  output  1  count == 2
- empty  output  1  count == 0
- stall_cnt  output  STALL_W  saturating count of cycles push_valid=1 while push_ready=0

## Operation
- Reset and flush: wptr = 0 and rptr = 0. Both are 2-bit (the LSB is the address, the MSB is the wrap bit). State = EMPTY.
- Address outputs: ram_waddr = wptr[0], ram_raddr = rptr[0].
- Handshake outputs (combinational):
  - push_ready = !full && !flush
  - pop_valid = !empty && !flush
- Transfer conditions:
  - Push accepted: push_valid && push_ready. ram_wen equals this term (combinational). wptr increments mod 4.
  - Pop accepted: pop_valid && pop_ready. rptr increments mod 4.
- State machine (count encodes the state: EMPTY = 0, ONE = 1, FULL = 2):
  - EMPTY: push -> ONE; otherwise stay. Pop is impossible.
  - ONE: push and pop together -> ONE (both pointers advance); push only -> FULL; pop only -> EMPTY.
  - FULL: pop -> ONE; otherwise stay. Push is impossible because push_ready = 0. There is no same-cycle pass-through when full.
  - The state must always agree with (wptr - rptr) mod 4. full means the pointer LSBs are equal and the MSBs differ; empty means the pointers are equal.
- Flush:
  - Flush takes priority over everything. Next state = EMPTY and both pointers = 0.
  - During the flush cycle push_ready = 0 and pop_valid = 0, so no transfer occurs and ram_wen = 0.
  - RAM contents are left as is.
- stall_cnt:
  - Increments on each cycle where push_valid && !push_ready && !flush.
  - Saturates at 2^STALL_W-1.
  - stall_clr clears it to 0 and beats a same-cycle increment.
  - flush does not clear it.
- Consumer and producer protocol: the consumer samples RAM q while pop_valid = 1. The producer must hold push_valid and d stable until accepted. The block does not check this.

## Timing
- Reset values (asynchronous, while rst_n = 0): count = 0, empty = 1, full = 0, push_ready = 1 (when flush = 0), pop_valid = 0, ram_wen = 0, ram_waddr = 0, ram_raddr = 0, stall_cnt = 0.
- Write-to-read latency is 1 cycle. A word accepted at edge N gives pop_valid = 1 after edge N, with the word on RAM q. There is no fall-through in the acceptance cycle.
- full and empty update on the edge following the accepting transfer. push_ready and pop_valid follow combinationally.
- Reset asserted mid-transfer: state returns to EMPTY immediately. A pending write on that edge is not counted.
- Wrap-around: after 4 pushes and 4 pops, the pointers return to 0 and the addresses alternate 0,1,0,1.

## Test plan
- Reset, then push A (edge 1) and push B (edge 2), no pops:
  - ram_waddr = 0 then 1.
  - count goes 1 then 2; full = 1 and push_ready = 0 after edge 2.
  - Holding push_valid = 1 for 3 more cycles gives stall_cnt = 3.
- From full, pop_ready = 1 for 2 cycles:
  - ram_raddr = 0 then 1, RAM q shows A then B.
  - count goes 2 -> 1 -> 0, empty = 1, pop_valid = 0.
- Push and pop together while count = 1, for 6 cycles:
  - count stays 1.
  - ram_waddr and ram_raddr alternate with a 1-entry offset; data order is preserved across the pointer wrap.
- Flush while count = 2 with push_valid = 1 and pop_ready = 1:
  - ram_wen = 0, no pop.
  - Next cycle count = 0, pointers 0, empty = 1.
  - stall_cnt is unchanged, except that the full-stall cycles before the flush still counted.
- STALL_W = 2 with push_valid held while full for 5 cycles: stall_cnt saturates at 3. stall_clr asserted together with another stall cycle gives stall_cnt = 0.
- Reset while count = 2: all outputs take their reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/k_fifo2_ctrl.sv
// k_fifo2_ctrl: pointer and flow-control sequencer for a 2-entry FIFO built
// around an external 2-entry dual-port RAM. The RAM writes on the clk edge
// when ram_wen is high and reads asynchronously. This block carries no data.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_valid/ready  producer handshake (data goes straight to RAM d)
//   pop_valid/ready   consumer handshake (data comes from RAM q)
//   flush             synchronous empty; dominates every transfer
//   stall_clr         synchronous clear of stall_cnt
//   ram_wen/waddr     RAM write port control
//   ram_raddr         RAM read address
//   count/full/empty  occupancy status
//   stall_cnt         saturating count of producer stall cycles
module k_fifo2_ctrl #(
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_valid,
  output logic               push_ready,
  input  logic               pop_ready,
  output logic               pop_valid,
  input  logic               flush,
  input  logic               stall_clr,
  output logic               ram_wen,
  output logic               ram_waddr,
  output logic               ram_raddr,
  output logic [1:0]         count,
  output logic               full,
  output logic               empty,
  output logic [STALL_W-1:0] stall_cnt
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  state_t     state, state_n;
  logic [1:0] wptr, rptr;   // bit 0 = RAM address, bit 1 = wrap bit
  logic       push_acc, pop_acc;

  assign full       = (state == S_FULL);
  assign empty      = (state == S_EMPTY);
  assign count      = state;
  assign push_ready = !full && !flush;
  assign pop_valid  = !empty && !flush;
  assign push_acc   = push_valid && push_ready;
  assign pop_acc    = pop_valid && pop_ready;
  assign ram_wen    = push_acc;
  assign ram_waddr  = wptr[0];
  assign ram_raddr  = rptr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = S_EMPTY;
    end else begin
      unique case (state)
        S_EMPTY: if (push_acc) state_n = S_ONE;
        S_ONE: begin
          if (push_acc && !pop_acc)      state_n = S_FULL;
          else if (!push_acc && pop_acc) state_n = S_EMPTY;
        end
        S_FULL:  if (pop_acc) state_n = S_ONE;
        default: state_n = S_EMPTY;
      endcase
    end
  end

  // Pointers advance only on accepted transfers, so (wptr - rptr) mod 4
  // always tracks the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= 2'd0;
      rptr <= 2'd0;
    end else if (flush) begin
      wptr <= 2'd0;
      rptr <= 2'd0;
    end else begin
      if (push_acc) wptr <= wptr + 2'd1;
      if (pop_acc)  rptr <= rptr + 2'd1;
    end
  end

  // Outside flush, push_ready is low only when full, so a stall is a
  // push attempt against a full FIFO. Clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall_clr)
      stall_cnt <= '0;
    else if (push_valid && !push_ready && !flush && stall_cnt != STALL_MAX)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_k_fifo2_ctrl.sv
// Bench for k_fifo2_ctrl: directed vector table, hand sequences for stall
// saturation and asynchronous reset, then random traffic against a
// queue-based reference model. A second instance with STALL_W = 2 shares
// the inputs to exercise counter saturation.
module tb_k_fifo2_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       push_valid, pop_ready, flush, stall_clr;
  logic [7:0] d;
  logic       push_ready, pop_valid, ram_wen, ram_waddr, ram_raddr, full, empty;
  logic [1:0] count;
  logic [7:0] stall_cnt;
  // narrow-counter instance outputs
  logic       push_ready2, pop_valid2, ram_wen2, ram_waddr2, ram_raddr2, full2, empty2;
  logic [1:0] count2;
  logic [1:0] stall_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  k_fifo2_ctrl #(.STALL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_ready(push_ready),
    .pop_ready(pop_ready), .pop_valid(pop_valid), .flush(flush), .stall_clr(stall_clr),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .count(count), .full(full), .empty(empty), .stall_cnt(stall_cnt)
  );

  k_fifo2_ctrl #(.STALL_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_ready(push_ready2),
    .pop_ready(pop_ready), .pop_valid(pop_valid2), .flush(flush), .stall_clr(stall_clr),
    .ram_wen(ram_wen2), .ram_waddr(ram_waddr2), .ram_raddr(ram_raddr2),
    .count(count2), .full(full2), .empty(empty2), .stall_cnt(stall_cnt2)
  );

  // 2-entry RAM: synchronous write, asynchronous read.
  logic [7:0] mem [2];
  always @(posedge clk) if (ram_wen) mem[ram_waddr] <= d;
  wire [7:0] q = mem[ram_raddr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int pv, input int pr, input int fl, input int sc, input int dd);
    push_valid = pv[0];
    pop_ready  = pr[0];
    flush      = fl[0];
    stall_clr  = sc[0];
    d          = dd[7:0];
  endtask

  // Called at a negedge: drive, let it settle, then advance to the next negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int pv, pr, fl, sc, d;
    int cnt, f, e, prdy, pvld, wen, wa, ra, stall, chkq, q;
  } vec_t;

  vec_t tbl [20];

  // Reference model state: FIFO contents plus accepted-transfer tallies.
  int q_model[$];
  int wcnt, rcnt, stall8, stall2;

  task automatic model_reset();
    q_model.delete();
    wcnt = 0; rcnt = 0; stall8 = 0; stall2 = 0;
  endtask

  task automatic model_cycle(input int pv, input int pr, input int fl, input int sc, input int dd);
    int  sz;
    bit  m_full, m_empty, m_prdy, m_pvld, m_wen, m_pop;
    sz      = q_model.size();
    m_full  = (sz == 2);
    m_empty = (sz == 0);
    m_prdy  = !m_full && (fl == 0);
    m_pvld  = !m_empty && (fl == 0);
    m_wen   = (pv != 0) && m_prdy;
    m_pop   = m_pvld && (pr != 0);
    set_in(pv, pr, fl, sc, dd);
    #1;
    chk("rnd_count", count, sz);
    chk("rnd_full", full, m_full);
    chk("rnd_empty", empty, m_empty);
    chk("rnd_push_ready", push_ready, m_prdy);
    chk("rnd_pop_valid", pop_valid, m_pvld);
    chk("rnd_ram_wen", ram_wen, m_wen);
    chk("rnd_waddr", ram_waddr, wcnt % 2);
    chk("rnd_raddr", ram_raddr, rcnt % 2);
    chk("rnd_stall8", stall_cnt, stall8);
    chk("rnd_stall2", stall_cnt2, stall2);
    if (m_pvld) chk("rnd_q", q, q_model[0]);
    tick();
    if (fl != 0) begin
      q_model.delete();
      wcnt = 0; rcnt = 0;
    end else begin
      if (m_pop) begin void'(q_model.pop_front()); rcnt++; end
      if (m_wen) begin q_model.push_back(dd & 8'hFF); wcnt++; end
    end
    if (sc != 0) begin
      stall8 = 0; stall2 = 0;
    end else if (pv != 0 && m_full && fl == 0) begin
      if (stall8 < 255) stall8++;
      if (stall2 < 3)   stall2++;
    end
  endtask

  initial begin
    // pv pr fl sc d | cnt f e prdy pvld wen wa ra stall chkq q
    tbl[0]  = '{1,0,0,0,'hA1, 0,0,1,1,0,1,0,0,0,0,0};
    tbl[1]  = '{1,0,0,0,'hB2, 1,0,0,1,1,1,1,0,0,1,'hA1};
    tbl[2]  = '{1,0,0,0,'hC3, 2,1,0,0,1,0,0,0,0,1,'hA1};
    tbl[3]  = '{1,0,0,0,'hC3, 2,1,0,0,1,0,0,0,1,1,'hA1};
    tbl[4]  = '{1,0,0,0,'hC3, 2,1,0,0,1,0,0,0,2,1,'hA1};
    tbl[5]  = '{0,1,0,0,0,    2,1,0,0,1,0,0,0,3,1,'hA1};
    tbl[6]  = '{0,1,0,0,0,    1,0,0,1,1,0,0,1,3,1,'hB2};
    tbl[7]  = '{1,1,0,0,'hC3, 0,0,1,1,0,1,0,0,3,0,0};
    tbl[8]  = '{1,1,0,0,'hD4, 1,0,0,1,1,1,1,0,3,1,'hC3};
    tbl[9]  = '{1,1,0,0,'hE5, 1,0,0,1,1,1,0,1,3,1,'hD4};
    tbl[10] = '{1,1,0,0,'hF6, 1,0,0,1,1,1,1,0,3,1,'hE5};
    tbl[11] = '{1,1,0,0,'h17, 1,0,0,1,1,1,0,1,3,1,'hF6};
    tbl[12] = '{1,1,0,0,'h28, 1,0,0,1,1,1,1,0,3,1,'h17};
    tbl[13] = '{1,1,0,0,'h39, 1,0,0,1,1,1,0,1,3,1,'h28};
    tbl[14] = '{1,0,0,0,'h4A, 1,0,0,1,1,1,1,0,3,1,'h39};
    tbl[15] = '{1,0,0,0,'h5B, 2,1,0,0,1,0,0,0,3,1,'h39};
    tbl[16] = '{1,1,1,0,'h5B, 2,1,0,0,0,0,0,0,4,0,0};
    tbl[17] = '{0,0,0,0,0,    0,0,1,1,0,0,0,0,4,0,0};
    tbl[18] = '{0,0,0,1,0,    0,0,1,1,0,0,0,0,4,0,0};
    tbl[19] = '{0,0,0,0,0,    0,0,1,1,0,0,0,0,0,0,0};

    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_push_ready", push_ready, 1);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_ram_wen", ram_wen, 0);
    chk("rst_stall", stall_cnt, 0);
    @(negedge clk);
    do_reset();

    // Directed table
    for (int i = 0; i < 20; i++) begin
      set_in(tbl[i].pv, tbl[i].pr, tbl[i].fl, tbl[i].sc, tbl[i].d);
      #1;
      chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("tbl%0d_full", i), full, tbl[i].f);
      chk($sformatf("tbl%0d_empty", i), empty, tbl[i].e);
      chk($sformatf("tbl%0d_push_ready", i), push_ready, tbl[i].prdy);
      chk($sformatf("tbl%0d_pop_valid", i), pop_valid, tbl[i].pvld);
      chk($sformatf("tbl%0d_ram_wen", i), ram_wen, tbl[i].wen);
      chk($sformatf("tbl%0d_waddr", i), ram_waddr, tbl[i].wa);
      chk($sformatf("tbl%0d_raddr", i), ram_raddr, tbl[i].ra);
      chk($sformatf("tbl%0d_stall", i), stall_cnt, tbl[i].stall);
      if (tbl[i].chkq != 0) chk($sformatf("tbl%0d_q", i), q, tbl[i].q);
      tick();
    end

    // Narrow counter saturates at 3; clear beats a same-cycle stall.
    do_reset();
    set_in(1, 0, 0, 0, 'h11); tick();
    set_in(1, 0, 0, 0, 'h22); tick();
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("sat_stall2", stall_cnt2, 3);
    chk("sat_stall8", stall_cnt, 5);
    chk("sat_full2", full2, 1);
    set_in(1, 0, 0, 1, 'h22);
    tick();
    #1;
    chk("clr_stall2", stall_cnt2, 0);
    chk("clr_stall8", stall_cnt, 0);

    // Asynchronous reset while full: outputs recover before any clk edge.
    set_in(0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_push_ready", push_ready, 1);
    chk("arst_pop_valid", pop_valid, 0);
    chk("arst_ram_wen", ram_wen, 0);
    chk("arst_waddr", ram_waddr, 0);
    chk("arst_raddr", ram_raddr, 0);
    chk("arst_stall2", stall_cnt2, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic against the queue model.
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      model_cycle(($urandom_range(0, 3) != 0) ? 1 : 0,
                  ($urandom_range(0, 2) == 0) ? 1 : 0,
                  ($urandom_range(0, 15) == 0) ? 1 : 0,
                  ($urandom_range(0, 19) == 0) ? 1 : 0,
                  int'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
